// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and widths for the multiplier-sharing sequencer.
// State encoding is fixed so the state register can be decoded directly in debug.
package mul_share_arbiter_pkg;

    localparam int OPW = 8;
    localparam int PW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between client engines (master) and the sequencer (slave).
interface mul_share_arbiter_if
    import mul_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [OPW*NREQ-1:0]  req_x;
    logic [OPW*NREQ-1:0]  req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [PW-1:0]        rsp_p;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/mul_share_arbiter_mult.sv
// Combinational 8x8 two's-complement array multiplier with a full 16-bit product.
module mul_share_arbiter_mult (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);

    // Sign-extend to the product width so the low 16 bits are the exact signed product.
    assign p = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});

endmodule

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from rr_last+1 upward (mod NREQ) for the first request.
module mul_share_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_last,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            // rr_last < NREQ and k <= NREQ, so one conditional subtract is enough to wrap.
            sum = {1'b0, rr_last} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Time-shares one combinational multiplier among NREQ requesters with a registered,
// handshaked interface and a programmable operand settle time.
//
// state | meaning
// IDLE  | arbitrating; req_ready asserted to the round-robin winner
// WAIT  | operands held on the multiplier for SETTLE_CYC cycles
// RESP  | product presented on the response channel until accepted
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_share_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_last_q, rr_last_d;
    logic [OPW-1:0]  op_x_q, op_x_d;
    logic [OPW-1:0]  op_y_q, op_y_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PW-1:0]   rsp_p_q, rsp_p_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     ops_done_q, ops_done_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [PW-1:0]   p;

    mul_share_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (bus.req_valid),
        .rr_last (rr_last_q),
        .en      (state_q == ST_IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    mul_share_arbiter_mult u_mult (
        .x (op_x_q),
        .y (op_y_q),
        .p (p)
    );

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        op_id_d     = op_id_q;
        cnt_d       = cnt_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        ops_done_d  = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_x_d    = bus.req_x[{gnt_idx, 3'b000} +: OPW];
                    op_y_d    = bus.req_y[{gnt_idx, 3'b000} +: OPW];
                    op_id_d   = gnt_idx;
                    rr_last_d = gnt_idx;
                    cnt_d     = 4'(SETTLE_CYC - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_p_d     = p;
                    rsp_id_d    = op_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= IDW'(NREQ - 1);
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_id_q     <= '0;
            cnt_q       <= '0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            op_id_q     <= op_id_d;
            cnt_q       <= cnt_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign busy          = (state_q != ST_IDLE);
    assign ops_done      = ops_done_q;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Sequencer and arbiter that time-shares one combinational 8x8 two's-complement array multiplier (ports x, y, p; p = signed x * signed y, 16-bit) among NREQ requesters. Each requester has a valid/ready request channel. The block round-robin arbitrates, registers the winning operands onto the multiplier inputs and waits a configurable settle time. It then captures the product and returns it on a single shared response channel tagged with the requester index. The block sits between client engines and the multiplier, and gives the purely combinational array a registered, handshaked interface.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must be ceil(log2(NREQ)), minimum 1
SETTLE_CYC, 1, cycles the multiplier inputs are held before product capture (1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high
req_x  in  8*NREQ  multiplicand, requester i at [8i+7:8i], two's complement
req_y  in  8*NREQ  multiplier, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of requester that owns rsp_p
rsp_p  out  16  signed product
busy  out  1  high in any state other than IDLE
ops_done  out  16  count of completed response handshakes; wraps 16'hFFFF to 0

Behaviour:
- States: IDLE, WAIT, RESP. Reset: state=IDLE, rr_last=NREQ-1, op_x=op_y=0, rsp_p=0, rsp_id=0, rsp_valid=0, ops_done=0, busy=0, req_ready=0.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching rr_last+1, rr_last+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle. req_ready is 0 in all other states and for all other bits.
  - On the accept edge: op_x<=req_x[g], op_y<=req_y[g], op_id<=g, rr_last<=g, settle counter<=SETTLE_CYC-1, state->WAIT.
  - No valid request: remain in IDLE.
- WAIT:
  - op_x and op_y drive the multiplier; they are stable for the whole state.
  - Counter is 0 at the edge: rsp_p<=p, rsp_id<=op_id, rsp_valid<=1, state->RESP. Otherwise the counter decrements.
- RESP:
  - rsp_valid=1. rsp_p and rsp_id are held stable until handshake.
  - rsp_valid & rsp_ready at the edge: rsp_valid<=0, ops_done<=ops_done+1, state->IDLE.
  - No new request is accepted in the same cycle (one-cycle bubble).
- Latency: request accepted in cycle 0, rsp_valid first high in cycle SETTLE_CYC+1 (cycle 2 at the default). Peak throughput is 1 op per SETTLE_CYC+2 cycles.
- Requesters hold req_valid and operands until req_ready. Deasserting req_valid without ready is tolerated: arbitration is re-evaluated every IDLE cycle.
- Arithmetic: full signed 16-bit result with no truncation or saturation. -128*-128 = 16'h4000.
- rst wins over every event. Reset mid-WAIT or mid-RESP discards the in-flight operation with no response, and rr_last returns to NREQ-1, so requester 0 has top priority after reset.
- rsp_ready high while rsp_valid is low has no effect.
- NREQ=1 degenerates to a pass-through sequencer with rsp_id always 0.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2
  - operand width constant 8 and product width constant 16
- Sub-module rr_arbiter (NREQ-wide):
  - inputs: req vector, rr_last, enable
  - outputs: one-hot grant and grant index
  - purely combinational
- The existing array multiplier is instantiated once, unmodified.

Test Plan:
1. Requester 0 only, x=8'd3, y=8'd5, rsp_ready=1 -> req_ready[0] high in cycle 0; rsp_valid high in cycle 2 with rsp_p=16'h000F, rsp_id=0; ops_done=1 after the handshake.
2. Signed corners, sequentially from requester 1:
   - (8'h80, 8'h80) -> 16'h4000
   - (8'hFF, 8'h01) -> 16'hFFFF
   - (8'h7F, 8'h80) -> 16'hC080
   - (8'h00, 8'h9C) -> 16'h0000
   All with rsp_id=1.
3. All four req_valid held high with distinct operands -> grant order 0,1,2,3,0,1. Never two req_ready bits high at once, and each rsp_id matches the grant.
4. Last grant 2, then only requesters 1 and 3 valid -> 3 is granted next, then 1.
5. rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_p and rsp_id stable; req_ready=0 throughout; ops_done unchanged until the handshake cycle, then +1.
6. rst pulsed for one cycle during WAIT of a requester-2 op -> next cycle IDLE, rsp_valid=0, ops_done=0, no response for the dropped op. With requesters 0 and 2 then valid, requester 0 is granted first.
